// File: rtl/qar_timer_arb.sv
// Two-master round-robin arbiter in front of the QAR timer register port.
// Locked sequences, a lock timeout, a one-cycle issue stage and a one-cycle return stage.
module qar_timer_arb #(
  parameter int         LOCK_TIMEOUT = 16,
  parameter logic [5:0] MAX_ADDR     = 6'h13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [5:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [5:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        t_bus_write,
  output logic        t_bus_read,
  output logic [5:0]  t_addr_word,
  output logic [31:0] t_wdata,
  input  logic [31:0] t_rdata,
  output logic        addr_err,
  output logic        lock_err
);

  typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} state_t;

  state_t      state_reg;
  logic        last_reg;
  logic [7:0]  lock_cnt_reg;
  logic        wr_reg, rd_reg, err_reg;
  logic [5:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic        rd_pend_reg, rd_mst_reg, rd_zero_reg;
  logic        rvalid0_reg, rvalid1_reg;
  logic [31:0] rdata0_reg, rdata1_reg;

  logic        g0, g1, any_gnt, owner_idle, timeout, bad;
  logic        sel_we, sel_lock;
  logic [5:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic [7:0]  cnt_inc;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state_reg)
      UNLOCKED: begin
        if (m0_req && m1_req) begin
          g0 = last_reg;
          g1 = !last_reg;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
      LOCK0:   g0 = m0_req;
      LOCK1:   g1 = m1_req;
      default: ;
    endcase
    g0 = g0 && rst_n;
    g1 = g1 && rst_n;
  end

  assign any_gnt    = g0 || g1;
  assign sel_we     = g1 ? m1_we    : m0_we;
  assign sel_lock   = g1 ? m1_lock  : m0_lock;
  assign sel_addr   = g1 ? m1_addr  : m0_addr;
  assign sel_wdata  = g1 ? m1_wdata : m0_wdata;
  assign bad        = sel_addr > MAX_ADDR;

  // An owner grant in the same cycle always beats the timeout.
  assign owner_idle = (state_reg == LOCK0 && !g0) || (state_reg == LOCK1 && !g1);
  assign cnt_inc    = lock_cnt_reg + 8'd1;
  assign timeout    = rst_n && owner_idle && (cnt_inc == 8'(LOCK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= UNLOCKED;
      last_reg     <= 1'b1;
      lock_cnt_reg <= 8'd0;
      wr_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      err_reg      <= 1'b0;
      addr_reg     <= 6'd0;
      wdata_reg    <= 32'd0;
      rd_pend_reg  <= 1'b0;
      rd_mst_reg   <= 1'b0;
      rd_zero_reg  <= 1'b0;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
      rdata0_reg   <= 32'd0;
      rdata1_reg   <= 32'd0;
    end else begin
      if (any_gnt) begin
        last_reg     <= g1;
        lock_cnt_reg <= 8'd0;
        state_reg    <= sel_lock ? (g1 ? LOCK1 : LOCK0) : UNLOCKED;
      end else if (owner_idle) begin
        if (timeout) begin
          state_reg    <= UNLOCKED;
          lock_cnt_reg <= 8'd0;
        end else begin
          lock_cnt_reg <= cnt_inc;
        end
      end

      wr_reg  <= any_gnt && sel_we && !bad;
      rd_reg  <= any_gnt && !sel_we && !bad;
      err_reg <= any_gnt && bad;
      if (any_gnt) begin
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
      end

      // Rejected reads still return, with zero data.
      rd_pend_reg <= any_gnt && !sel_we;
      rd_mst_reg  <= g1;
      rd_zero_reg <= bad;
      rvalid0_reg <= rd_pend_reg && !rd_mst_reg;
      rvalid1_reg <= rd_pend_reg && rd_mst_reg;
      if (rd_pend_reg && !rd_mst_reg) rdata0_reg <= rd_zero_reg ? 32'd0 : t_rdata;
      if (rd_pend_reg && rd_mst_reg)  rdata1_reg <= rd_zero_reg ? 32'd0 : t_rdata;
    end
  end

  assign m0_gnt      = g0;
  assign m1_gnt      = g1;
  assign lock_err    = timeout;
  // Strobes issued just before a reset edge are suppressed so nothing leaks into reset.
  assign t_bus_write = wr_reg && rst_n;
  assign t_bus_read  = rd_reg && rst_n;
  assign addr_err    = err_reg && rst_n;
  assign t_addr_word = addr_reg;
  assign t_wdata     = wdata_reg;
  assign m0_rvalid   = rvalid0_reg;
  assign m1_rvalid   = rvalid1_reg;
  assign m0_rdata    = rdata0_reg;
  assign m1_rdata    = rdata1_reg;

endmodule

// File: tb/tb_qar_timer_arb.sv
// Randomized bench for qar_timer_arb against a cycle-indexed event model and a timer register file.
module tb_qar_timer_arb;
  localparam int         TO   = 4;
  localparam logic [5:0] MAXA = 6'h13;
  localparam int         NCYC = 1500;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [5:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [5:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        t_bus_write, t_bus_read, addr_err, lock_err;
  logic [5:0]  t_addr_word;
  logic [31:0] t_wdata, t_rdata;

  qar_timer_arb #(.LOCK_TIMEOUT(TO), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .t_bus_write(t_bus_write), .t_bus_read(t_bus_read), .t_addr_word(t_addr_word),
    .t_wdata(t_wdata), .t_rdata(t_rdata), .addr_err(addr_err), .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer register file: combinational read, write at the end of the strobe cycle.
  bit [31:0] tmem [64];
  assign t_rdata = tmem[t_addr_word];
  always @(posedge clk) if (t_bus_write) tmem[t_addr_word] <= t_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Expected observable events, indexed by the cycle in which they must appear.
  bit        e_wr  [NCYC+4];
  bit        e_rd  [NCYC+4];
  bit        e_err [NCYC+4];
  bit [5:0]  e_ta  [NCYC+4];
  bit [31:0] e_td  [NCYC+4];
  bit        e_rv  [2][NCYC+4];
  bit [31:0] e_rval[2][NCYC+4];
  bit [31:0] e_rdat[2][NCYC+4];
  bit [31:0] shadow[64];

  // Master request state and arbitration model.
  bit        pend[2], we_q[2], lk_q[2];
  bit [5:0]  ad_q[2];
  bit [31:0] wd_q[2];
  int owner, last, idle, g, rst_left, p_req, p_lock;
  bit lk_exp, bad, forced_rst_done;

  task automatic drive_masters();
    m0_req = pend[0]; m0_we = we_q[0]; m0_addr = ad_q[0]; m0_wdata = wd_q[0]; m0_lock = lk_q[0];
    m1_req = pend[1]; m1_we = we_q[1]; m1_addr = ad_q[1]; m1_wdata = wd_q[1]; m1_lock = lk_q[1];
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; we_q[m] = 0; lk_q[m] = 0; ad_q[m] = '0; wd_q[m] = '0;
    end
    drive_masters();
    rst_n = 1'b0;
    owner = -1; last = 1; idle = 0; rst_left = 0; forced_rst_done = 0;
    repeat (3) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      p_req  = (c / 300 == 0) ? 90 : (c / 300 == 1) ? 40 : (c / 300 == 2) ? 15 : (c / 300 == 3) ? 95 : 60;
      p_lock = (c / 300 == 0) ? 30 : (c / 300 == 1) ? 60 : (c / 300 == 2) ? 80 : (c / 300 == 3) ? 5 : 40;
      if (rst_left == 0 && c > 10 && $urandom_range(0, 399) == 0) rst_left = 2;
      rst_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;

      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 99) < p_req) begin
          pend[m] = 1;
          we_q[m] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 9))
            0:       ad_q[m] = 6'($urandom_range(20, 63));
            1:       ad_q[m] = MAXA;
            2:       ad_q[m] = MAXA + 6'd1;
            default: ad_q[m] = 6'($urandom_range(0, 7));
          endcase
          wd_q[m] = $urandom;
          lk_q[m] = ($urandom_range(0, 99) < p_lock);
        end
      end
      drive_masters();
      #1;

      g = -1;
      if (rst_n) begin
        if (owner >= 0) g = pend[owner] ? owner : -1;
        else if (pend[0] && pend[1]) g = (last == 1) ? 0 : 1;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      lk_exp = rst_n && owner >= 0 && g != owner && (idle + 1 == TO);

      check_val("gnt0",     32'(m0_gnt),      32'(g == 0));
      check_val("gnt1",     32'(m1_gnt),      32'(g == 1));
      check_val("lock_err", 32'(lock_err),    32'(lk_exp));
      check_val("bus_wr",   32'(t_bus_write), 32'(rst_n && e_wr[c]));
      check_val("bus_rd",   32'(t_bus_read),  32'(rst_n && e_rd[c]));
      check_val("addr_err", 32'(addr_err),    32'(rst_n && e_err[c]));
      check_val("addr",     32'(t_addr_word), 32'(e_ta[c]));
      check_val("wdata",    t_wdata,          e_td[c]);
      check_val("rvalid0",  32'(m0_rvalid),   32'(e_rv[0][c]));
      check_val("rvalid1",  32'(m1_rvalid),   32'(e_rv[1][c]));
      check_val("rdata0",   m0_rdata,         e_rdat[0][c]);
      check_val("rdata1",   m1_rdata,         e_rdat[1][c]);

      if (!rst_n) begin
        owner = -1; last = 1; idle = 0;
        e_ta[c+1] = '0; e_td[c+1] = '0;
        e_wr[c+1] = 0; e_rd[c+1] = 0; e_err[c+1] = 0;
        for (int m = 0; m < 2; m++) begin
          e_rv[m][c+1] = 0; e_rv[m][c+2] = 0; e_rdat[m][c+1] = '0;
        end
      end else begin
        if (e_wr[c]) shadow[e_ta[c]] = e_td[c];
        for (int m = 0; m < 2; m++)
          e_rdat[m][c+1] = e_rv[m][c+1] ? e_rval[m][c+1] : e_rdat[m][c];
        e_ta[c+1] = e_ta[c];
        e_td[c+1] = e_td[c];
        if (g >= 0) begin
          bad   = ad_q[g] > MAXA;
          last  = g;
          idle  = 0;
          owner = lk_q[g] ? g : -1;
          e_ta[c+1]  = ad_q[g];
          e_td[c+1]  = wd_q[g];
          e_wr[c+1]  = we_q[g] && !bad;
          e_rd[c+1]  = !we_q[g] && !bad;
          e_err[c+1] = bad;
          if (!we_q[g]) begin
            e_rv[g][c+2]   = 1;
            e_rval[g][c+2] = bad ? 32'd0 : shadow[ad_q[g]];
          end
          $display("cyc %0d m%0d %s addr=%h wdata=%h lock=%0d%s", c, g, we_q[g] ? "write" : "read",
                   ad_q[g], wd_q[g], lk_q[g], bad ? " rejected" : "");
          pend[g] = 0;
          // Reset right after an m1 read grant: the read must never reach the timer or return.
          if (!forced_rst_done && c >= 700 && g == 1 && !we_q[g]) begin
            forced_rst_done = 1;
            rst_left = 2;
          end
        end else if (owner >= 0) begin
          idle++;
          if (idle == TO) begin
            owner = -1;
            idle  = 0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qar_timer_arb.md
# qar_timer_arb

Two-master arbiter that shares the single register port of the QAR timer peripheral between the CPU load/store unit (master 0) and the PWM/DMA sequencer (master 1). It round-robins single-word accesses, supports locked read-modify-write sequences such as status clear-after-read, and rejects out-of-range addresses. It drives the timer's `bus_write`, `bus_read`, `addr_word` and `wdata` inputs from registers, and returns its combinational `rdata` to the granted master.

## Interface

**Parameters**
- `LOCK_TIMEOUT`, default 16: idle cycles a lock may be held without an owner request before forced release (range 1..255).
- `MAX_ADDR`, default 6'h13: highest valid timer word address.

**Ports**
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `m0_req`, `m1_req`  in  1: access request; held with its fields stable until `gnt`.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  6: timer word address.
- `m0_wdata`, `m1_wdata`  in  32: write data.
- `m0_lock`, `m1_lock`  in  1: keep ownership after this access.
- `m0_gnt`, `m1_gnt`  out  1: combinational; request accepted this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1: read data valid, one-cycle pulse.
- `m0_rdata`, `m1_rdata`  out  32: read data; holds its value until the next rvalid for that master.
- `t_bus_write`, `t_bus_read`  out  1: timer strobes; never both high.
- `t_addr_word`  out  6: address to the timer.
- `t_wdata`  out  32: write data to the timer.
- `t_rdata`  in  32: timer read data, combinational on `t_addr_word`.
- `addr_err`  out  1: one-cycle pulse for a rejected access.
- `lock_err`  out  1: one-cycle pulse for a forced lock release.

## Operation

**States**
- `UNLOCKED`, `LOCK0`, `LOCK1`. Reset state is `UNLOCKED`.

**Arbitration in `UNLOCKED`**
- If exactly one `req` is high, that master is granted.
- If both are high, the master that was not granted last wins. `last` resets to 1, so master 0 wins the first tie.
- At most one `gnt` is high per cycle. Grants may occur on consecutive cycles.

**Arbitration in `LOCKn`**
- Only master n can be granted. The other master's request stalls, with `gnt` low.

**Lock transitions**
- A grant with `lock=1` enters or stays in `LOCKn` for the granted master.
- A grant from the owner with `lock=0` returns to `UNLOCKED` after that access. The other master becomes eligible the next cycle.

**Lock timeout**
- An 8-bit counter increments each `LOCKn` cycle in which the owner is not granted. It clears on every owner grant and on entry to `LOCKn`.
- When the counter reaches `LOCK_TIMEOUT`, the state goes to `UNLOCKED`, `lock_err` pulses, and the counter clears.

**Issue stage**
- The grant in cycle N loads the issue registers.
- In cycle N+1, exactly one of `t_bus_write` or `t_bus_read` is high, per `we`. `t_addr_word` and `t_wdata` hold the granted values.
- With no grant, both strobes are 0. Address and data hold their last value.

**Out-of-range access**
- An address greater than `MAX_ADDR` is still granted but is not forwarded: both strobes stay 0 in N+1.
- `addr_err` pulses in N+1.
- A rejected read still returns `rvalid` in N+2 with rdata = 0.
- A rejected write is dropped.

**Read return**
- `t_rdata` is captured at the edge ending N+1, routed to the granted master.
- `mX_rvalid` pulses in N+2.
- Writes produce no rvalid.

## Timing

**Latency**
- Request to `gnt`: 0 cycles when uncontended.
- Grant to timer strobe: 1 cycle.
- Grant to `rvalid`: 2 cycles.
- Throughput: 1 access per cycle.

**Ordering and visibility**
- A write granted in N, followed by a read of the same address granted in N+1, returns the new value. The timer register updates at the end of N+1; the read strobe is in N+2.

**Reset values** (when `rst_n=0` at an edge)
- All outputs are 0: gnt, rvalid, rdata, strobes, `t_addr_word`, `t_wdata`, `addr_err`, `lock_err`.
- Internal state: `UNLOCKED`, `last=1`, lock counter 0.

**Reset mid-operation**
- In-flight issue and return stages are discarded: no strobe and no rvalid after reset.

**Simultaneous events**
- A timeout and an owner request in the same cycle: the grant wins and the counter clears, so no `lock_err`.
- A lock release and an other-master request in the same cycle: only the owner is granted. The other master is granted next cycle.

## Test plan

1. **Uncontended write then read:** m0 writes 0x0000_1234 to addr 0x1 in cycle 1, then reads addr 0x1 in cycle 2.
   - `t_bus_write` is high in cycle 2 and `t_bus_read` in cycle 3.
   - `m0_rvalid` pulses in cycle 4 with `m0_rdata` = 0x0000_1234.
2. **Round-robin:** both masters request continuously for 6 cycles with reads of addr 0x5.
   - Grant order is m0, m1, m0, m1, m0, m1.
   - No cycle has both gnt high.
3. **Locked RMW:** m1 reads 0x3 with lock=1 and then writes 0x3 with lock=0, while m0 requests throughout.
   - m0 is granted only in the cycle after m1's unlocked write.
4. **Lock timeout:** m0 takes the lock, then stays idle with `LOCK_TIMEOUT`=4.
   - `lock_err` pulses exactly 4 cycles after the grant.
   - A pending m1 request is granted the next cycle.
5. **Bad address:** m0 reads 0x20.
   - `addr_err` pulses in N+1 and both strobes stay 0.
   - `m0_rvalid` pulses in N+2 with rdata = 0.
6. **Reset mid-flight:** assert `rst_n=0` in the cycle after an m1 read grant.
   - No `t_bus_read` and no `m1_rvalid` follow.
   - After reset, a tie grants m0 first.
